fp_result_packer: RTL and testbench



---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_result_packer_if.sv | 32 +++
 rtl/fp_round_rne.sv | 20 ++
 rtl/fp_result_packer.sv | 149 ++++++++++++++
 tb/tb_fp_result_packer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the IEEE-754 single-precision result packer:
// field widths, mantissa bit positions, special encodings, FSM states.
package fp_pkg;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int BIAS    = 127;

   // Working widths: exponent carries two guard bits (signed), mantissa
   // carries carry, hidden, fraction and G/R/S.
   localparam int EXPI_W  = EXP_W + 2;
   localparam int MANT_W  = FRAC_W + 5;
   localparam int SIG_W   = FRAC_W + 1;
   localparam int EXP_MAX = 2 * BIAS + 1;

   // Mantissa field positions
   localparam int CARRY_BIT  = MANT_W - 1;
   localparam int HIDDEN_BIT = MANT_W - 2;
   localparam int FRAC_LSB   = 3;
   localparam int G_BIT      = 2;
   localparam int R_BIT      = 1;
   localparam int S_BIT      = 0;

   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   typedef logic signed [EXPI_W-1:0] exp_t;
   typedef logic [MANT_W-1:0]        mant_t;

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   // True when the mantissa still needs a normalisation step: a carry to
   // absorb, or a missing hidden bit that can be recovered without
   // dropping the exponent below 1 (below that the result is subnormal).
   function automatic logic needs_norm(input mant_t m, input exp_t e);
      return m[CARRY_BIT] || (!m[HIDDEN_BIT] && (e > exp_t'(1)));
   endfunction

endpackage

// File: rtl/fp_result_packer_if.sv
// Handshake bundle between the adder datapath, the result packer and the
// downstream consumer. The packer takes the slave side.
interface fp_result_packer_if
   import fp_pkg::*;
   ();

   logic              in_valid;
   logic              in_ready;
   logic              in_special;
   logic [31:0]       in_special_val;
   logic              in_sign;
   logic [EXPI_W-1:0] in_exp;
   logic [MANT_W-1:0] in_mant;
   logic [31:0]       out;
   logic              out_valid;
   logic              out_ready;
   logic              overflow;
   logic              underflow;

   modport slave (
      input  in_valid, in_special, in_special_val, in_sign, in_exp, in_mant,
      input  out_ready,
      output in_ready, out, out_valid, overflow, underflow
   );

   modport master (
      output in_valid, in_special, in_special_val, in_sign, in_exp, in_mant,
      output out_ready,
      input  in_ready, out, out_valid, overflow, underflow
   );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 24-bit significand with guard/round/sticky.
// Purely combinational; o_carry flags a wrap past the hidden bit.
module fp_round_rne
   import fp_pkg::*;
(
   input  logic [SIG_W-1:0] i_sig,
   input  logic             i_g,
   input  logic             i_r,
   input  logic             i_s,
   output logic [SIG_W-1:0] o_sig,
   output logic             o_carry
);

   logic w_round_up;

   // Exact ties (G=1, R=S=0) only round up when the kept lsb is odd.
   assign w_round_up = i_g & (i_r | i_s | i_sig[0]);
   assign {o_carry, o_sig} = {1'b0, i_sig} + (SIG_W + 1)'(w_round_up);

endmodule

// File: rtl/fp_result_packer.sv
// IEEE-754 single-precision result packer: iterative normalisation,
// round-to-nearest-even and packing, valid/ready on both sides.
// Build option: define FP_PACK_FTZ_EN to flush subnormal results to
// signed zero (underflow still flagged); default is gradual underflow.
module fp_result_packer
   import fp_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   fp_result_packer_if.slave   bus
);

   state_t          r_state;
   logic            r_sign;
   exp_t            r_exp;
   mant_t           r_mant;
   logic [31:0]     r_out;
   logic            r_out_valid;
   logic            r_overflow;
   logic            r_underflow;
   logic            r_in_ready;

   mant_t           w_norm_mant;
   exp_t            w_norm_exp;
   logic            w_norm_more;
   logic [SIG_W-1:0] w_sig_rnd;
   logic            w_carry;
   logic [SIG_W-1:0] w_sig_fin;
   exp_t            w_exp_fin;
   logic [31:0]     w_round_word;
   logic            w_round_ovf;
   logic            w_round_unf;

   // One normalisation step; the loop exits as soon as the stepped value
   // is already normalised, so no cycle is spent just deciding to stop.
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      w_norm_mant = r_mant;
      w_norm_exp  = r_exp;
      if (r_mant[CARRY_BIT]) begin
         w_norm_mant = {1'b0, r_mant[CARRY_BIT:G_BIT], |r_mant[R_BIT:S_BIT]};
         w_norm_exp  = r_exp + exp_t'(1);
      end else if (!r_mant[HIDDEN_BIT] && (r_exp > exp_t'(1))) begin
         w_norm_mant = r_mant << 1;
         w_norm_exp  = r_exp - exp_t'(1);
      end
      w_norm_more = needs_norm(w_norm_mant, w_norm_exp);
   end

   fp_round_rne u_round (
      .i_sig   (r_mant[HIDDEN_BIT:FRAC_LSB]),
      .i_g     (r_mant[G_BIT]),
      .i_r     (r_mant[R_BIT]),
      .i_s     (r_mant[S_BIT]),
      .o_sig   (w_sig_rnd),
      .o_carry (w_carry)
   );

   // Post-round renormalisation and packing into the final word and flags.
   always_comb begin
      w_sig_fin    = w_carry ? {w_carry, w_sig_rnd[SIG_W-1:1]} : w_sig_rnd;
      w_exp_fin    = r_exp + (w_carry ? exp_t'(1) : exp_t'(0));
      w_round_word = {r_sign, w_exp_fin[EXP_W-1:0], w_sig_fin[FRAC_W-1:0]};
      w_round_ovf  = 1'b0;
      w_round_unf  = 1'b0;
      if (w_exp_fin >= exp_t'(EXP_MAX)) begin
         w_round_word = {r_sign, POS_INF[30:0]};
         w_round_ovf  = 1'b1;
      end else if (!w_sig_fin[FRAC_W]) begin
         // Hidden bit still clear means exp stopped at 1: subnormal.
         w_round_unf  = 1'b1;
`ifdef FP_PACK_FTZ_EN
         w_round_word = {r_sign, 31'b0};
`else
         w_round_word = {r_sign, {EXP_W{1'b0}}, w_sig_fin[FRAC_W-1:0]};
`endif
      end
   end

   // Control FSM with registered outputs: capture, normalise, round, hold.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values, independent of statement order.
      if (rst) begin
         r_state     <= IDLE;
         r_sign      <= 1'b0;
         r_exp       <= '0;
         r_mant      <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_in_ready <= 1'b0;
                  r_sign     <= bus.in_sign;
                  r_exp      <= bus.in_exp;
                  r_mant     <= bus.in_mant;
                  r_overflow  <= 1'b0;
                  r_underflow <= 1'b0;
                  if (bus.in_special) begin
                     r_out       <= bus.in_special_val;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else if (bus.in_mant == '0) begin
                     r_out       <= 32'h0000_0000;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else if (needs_norm(bus.in_mant, bus.in_exp)) begin
                     r_state <= NORM;
                  end else begin
                     r_state <= ROUND;
                  end
               end
            end
            NORM: begin
               r_mant <= w_norm_mant;
               r_exp  <= w_norm_exp;
               if (!w_norm_more) r_state <= ROUND;
            end
            ROUND: begin
               r_out       <= w_round_word;
               r_overflow  <= w_round_ovf;
               r_underflow <= w_round_unf;
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out       = r_out;
   assign bus.out_valid = r_out_valid;
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_fp_result_packer.sv
// Scoreboard bench for fp_result_packer: directed vectors push expected
// words, a monitor pops and compares on each output handshake.
module tb_fp_result_packer;
   import fp_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] word;
      logic        ovf;
      logic        unf;
      int          lat;
      int          acc_cyc;
   } sb_item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   sb_item_t sb_q[$];

`ifdef FP_PACK_FTZ_EN
   localparam logic [31:0] SUBN_WORD = 32'h8000_0000;
`else
   localparam logic [31:0] SUBN_WORD = 32'h8040_0000;
`endif

   fp_result_packer_if bus_if ();

   fp_result_packer u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Drive one word; called at posedge+1. Returns at posedge+1 after accept.
   task automatic send(input string name, input logic spc,
                       input logic [31:0] sval, input logic sgn,
                       input logic [EXPI_W-1:0] e, input logic [MANT_W-1:0] m,
                       input logic [31:0] word, input logic ovf,
                       input logic unf, input int lat, input bit push);
      int budget = 0;
      bus_if.in_valid       = 1'b1;
      bus_if.in_special     = spc;
      bus_if.in_special_val = sval;
      bus_if.in_sign        = sgn;
      bus_if.in_exp         = e;
      bus_if.in_mant        = m;
      while (!bus_if.in_ready && budget < 200) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!bus_if.in_ready) begin
         check({name, "_accept_timeout"}, 32'd0, 32'd1);
         bus_if.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus_if.in_valid = 1'b0;
      if (push) sb_q.push_back('{name, word, ovf, unf, lat, cyc});
   endtask

   task automatic wait_drain();
      int budget = 0;
      while (sb_q.size() != 0 && budget < 500) begin
         @(posedge clk); #1;
         budget++;
      end
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: samples on the falling edge, compares on each handshake.
   initial begin
      bit       seen = 0;
      int       first_cyc = 0;
      sb_item_t it;
      forever begin
         @(negedge clk);
         if (!rst && bus_if.out_valid) begin
            if (!seen) begin
               seen      = 1;
               first_cyc = cyc;
            end
            if (bus_if.out_ready) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_out", bus_if.out, 32'hxxxx_xxxx);
               end else begin
                  it = sb_q.pop_front();
                  check({it.name, "_out"}, bus_if.out, it.word);
                  check({it.name, "_ovf"}, 32'(bus_if.overflow), 32'(it.ovf));
                  check({it.name, "_unf"}, 32'(bus_if.underflow), 32'(it.unf));
                  if (it.lat > 0)
                     check({it.name, "_lat"}, 32'(first_cyc - it.acc_cyc + 1),
                           32'(it.lat));
               end
               seen = 0;
            end
         end
      end
   end

   initial begin
      int budget;
      bus_if.in_valid       = 1'b0;
      bus_if.in_special     = 1'b0;
      bus_if.in_special_val = '0;
      bus_if.in_sign        = 1'b0;
      bus_if.in_exp         = '0;
      bus_if.in_mant        = '0;
      bus_if.out_ready      = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      check("rst_out", bus_if.out, 32'd0);
      check("rst_flags", {30'd0, bus_if.overflow, bus_if.underflow}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);

      // name, special, sval, sign, exp, mant, expected, ovf, unf, latency, push
      send("add_3p7",     0, 0,       0, 10'd128, 28'hECCCCD0, 32'h40ECCCCD, 0, 0, 3, 1);
      send("byp_qnan",    1, QNAN,    0, 10'd1,   28'h0000000, QNAN,         0, 0, 1, 1);
      send("byp_ninf",    1, NEG_INF, 1, 10'd1,   28'h4000000, NEG_INF,      0, 0, 1, 1);
      send("cancel_zero", 0, 0,       1, 10'd5,   28'h0000000, 32'h00000000, 0, 0, 1, 1);
      send("lshift4",     0, 0,       0, 10'd127, 28'h0400000, 32'h3D800000, 0, 0, 6, 1);
      send("ovf_carry",   0, 0,       0, 10'd254, 28'hC000000, 32'h7F800000, 1, 0, 3, 1);
      send("ovf_rnd_neg", 0, 0,       1, 10'd254, 28'h7FFFFFC, 32'hFF800000, 1, 0, 2, 1);
      send("rne_tie_even",0, 0,       0, 10'd127, 28'h4000004, 32'h3F800000, 0, 0, 2, 1);
      send("rne_tie_odd", 0, 0,       0, 10'd127, 28'h400000C, 32'h3F800002, 0, 0, 2, 1);
      send("rne_carry",   0, 0,       0, 10'd127, 28'h7FFFFFE, 32'h40000000, 0, 0, 2, 1);
      send("sticky_shr",  0, 0,       0, 10'd127, 28'hC000009, 32'h40400001, 0, 0, 3, 1);
      send("subnormal",   0, 0,       1, 10'd1,   28'h2000000, SUBN_WORD,    0, 1, 2, 1);
      send("sub_to_norm", 0, 0,       0, 10'd1,   28'h3FFFFFC, 32'h00800000, 0, 0, 2, 1);
      wait_drain();

      // Backpressure: result and flags must hold while out_ready is low.
      bus_if.out_ready = 1'b0;
      send("bp_3p7", 0, 0, 0, 10'd128, 28'hECCCCD0, 32'h40ECCCCD, 0, 0, 3, 1);
      budget = 0;
      while (!bus_if.out_valid && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      check("bp_valid_timeout", 32'(bus_if.out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_out", bus_if.out, 32'h40ECCCCD);
         check("bp_hold_valid", 32'(bus_if.out_valid), 32'd1);
         check("bp_hold_flags", {30'd0, bus_if.overflow, bus_if.underflow}, 32'd0);
         check("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus_if.out_ready = 1'b1;
      wait_drain();

      // Reset in the middle of normalisation: the word must vanish.
      send("aborted", 0, 0, 0, 10'd127, 28'h0400000, 32'h3D800000, 0, 0, 6, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_out_valid", 32'(bus_if.out_valid), 32'd0);
      check("abort_in_ready", 32'(bus_if.in_ready), 32'd1);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      send("post_reset", 0, 0, 0, 10'd127, 28'h400000C, 32'h3F800002, 0, 0, 2, 1);
      wait_drain();
      repeat (5) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
